lfsr_spike_encoder_mc: RTL and testbench

Multi-channel, parametrised rate encoder. It converts one buffered image into parallel Bernoulli spike trains over a programmable window of cycles.
- Pixels stream in over a valid/ready port into an internal buffer.
- A start pulse runs the window. During the window, NUM_LFSR independent LFSRs are compared against the pixels, so correlation between neighbouring pixels is reduced.
- The block sits between the image loader and the first SNN layer, and signals frame completion for image sequencing.

---
 rtl/lfsr_enc_pkg.sv | 51 +++++
 rtl/lfsr_spike_encoder_mc_lfsr_gen.sv | 43 ++++
 rtl/lfsr_spike_encoder_mc.sv | 205 ++++++++++++++++++++
 tb/tb_lfsr_spike_encoder_mc.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_enc_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_enc_pkg
// Shared types and helpers for the LFSR spike encoder:
//   enc_state_e  - encoder FSM states (LOAD -> READY -> RUN -> DONE)
//   SEED_MULT    - golden-ratio multiplier used to spread generator seeds
//   tap_mask()   - XNOR Fibonacci tap mask for a given LFSR width
//   lfsr_seed()  - seed of generator k, truncated to the LFSR width
// ---------------------------------------------------------------------------
package lfsr_enc_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    localparam logic [31:0] SEED_MULT = 32'h9E3779B1;

    // Maximal-length tap sets (bit indices are 0-based).
    // Widths outside the supported set fall back to the 16-bit taps.
    function automatic logic [31:0] tap_mask(input int w);
        logic [31:0] m;
        case (w)
            8:       m = 32'h0000_00B8;  // 7,5,4,3
            12:      m = 32'h0000_0829;  // 11,5,3,0
            16:      m = 32'h0000_D008;  // 15,14,12,3
            24:      m = 32'h00E1_0000;  // 23,22,21,16
            32:      m = 32'h8020_0003;  // 31,21,1,0
            default: m = 32'h0000_D008;
        endcase
        return m;
    endfunction

    // All-ones is the XNOR lock-up state, so it is mapped to zero.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] base,
                                              input int          k,
                                              input int          w);
        logic [31:0] prod;
        logic [31:0] mask;
        logic [31:0] s;
        prod = 32'(k + 1) * SEED_MULT;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        s    = (base ^ prod) & mask;
        if (s == mask) begin
            s = 32'h0;
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_spike_encoder_mc_lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen
// One Fibonacci LFSR, shifting left, feedback bit 0 = XNOR of the taps.
// Ports:
//   clk, reset (async, active-high, loads SEED)
//   advance    - step the register this cycle
//   state      - current register value
// ---------------------------------------------------------------------------
module lfsr_gen
    import lfsr_enc_pkg::*;
#(
    parameter int                 LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  SEED   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(tap_mask(LFSR_W));

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = {state_q[LFSR_W-2:0], ~(^(state_q & TAPS))};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_spike_encoder_mc.sv
// ---------------------------------------------------------------------------
// lfsr_spike_encoder_mc
// Buffers one image, then emits NUM_PIXELS parallel Bernoulli spike trains
// for window_cycles cycles. Pixel i is compared against generator
// i mod NUM_LFSR.
//
// Pixel handshake: a beat transfers on a rising edge where pix_valid and
// pix_ready are both high; pix_ready is high only in LOAD and does not depend
// on pix_valid.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   pix_valid/data  pixel stream in raster order; pix_ready out
//   start           single-cycle pulse, honoured only in READY
//   window_cycles   window length, latched with start
//   busy            high in RUN and DONE
//   spike           registered spike vector, spike_valid marks it
//   frame_done      one-cycle pulse right after the last spike_valid cycle
//   lfsr0           generator 0 state (debug)
//   spike_total     (only with LFSR_SPIKE_COUNT_EN) spikes emitted in the
//                   window, stable while frame_done is high
// ---------------------------------------------------------------------------
module lfsr_spike_encoder_mc
    import lfsr_enc_pkg::*;
#(
    parameter int          NUM_PIXELS = 784,
    parameter int          PIX_W      = 8,
    parameter int          LFSR_W     = 16,
    parameter int          NUM_LFSR   = 4,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] BASE_SEED  = 32'hB60B
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [PIX_W-1:0]      pix_data,
    output logic                  pix_ready,
    input  logic                  start,
    input  logic [CNT_W-1:0]      window_cycles,
    output logic                  busy,
    output logic [NUM_PIXELS-1:0] spike,
    output logic                  spike_valid,
    output logic                  frame_done,
    output logic [LFSR_W-1:0]     lfsr0
`ifdef LFSR_SPIKE_COUNT_EN
    ,
    output logic [CNT_W+$clog2(NUM_PIXELS+1)-1:0] spike_total
`endif
);

    localparam int PTR_W = $clog2(NUM_PIXELS);
    localparam int SHIFT = LFSR_W - PIX_W;

    enc_state_e            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      win_q, win_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_PIXELS-1:0] spike_q, spike_d;
    logic                  spike_valid_q, spike_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  advance;
    logic                  pix_we;
    logic [NUM_PIXELS-1:0] cmp;

    // Image buffer: deliberately not reset, it is always reloaded before use.
    logic [PIX_W-1:0]      pix_buf_q [NUM_PIXELS];
    logic [LFSR_W-1:0]     lfsr_state [NUM_LFSR];

    for (genvar k = 0; k < NUM_LFSR; k++) begin : g_lfsr
        lfsr_gen #(
            .LFSR_W (LFSR_W),
            .SEED   (LFSR_W'(lfsr_seed(BASE_SEED, k, LFSR_W)))
        ) u_gen (
            .clk     (clk),
            .reset   (reset),
            .advance (advance),
            .state   (lfsr_state[k])
        );
    end

    // top PIX_W bits of the LFSR < pixel  <=>  LFSR < (pixel << SHIFT);
    // the full-width form avoids slicing and gives the same result.
    always_comb begin
        cmp = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            cmp[i] = lfsr_state[i % NUM_LFSR] < (LFSR_W'(pix_buf_q[i]) << SHIFT);
        end
    end

    assign pix_we = pix_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        cnt_d         = cnt_q;
        spike_d       = spike_q;
        spike_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        advance       = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (pix_we) begin
                    if (ptr_q == PTR_W'(NUM_PIXELS - 1)) begin
                        ptr_d   = '0;
                        state_d = ST_READY;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            ST_READY: begin
                if (start) begin
                    win_d   = window_cycles;
                    cnt_d   = '0;
                    state_d = (window_cycles == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                spike_d       = cmp;
                spike_valid_d = 1'b1;
                advance       = 1'b1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == win_q - CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The last RUN edge already raised spike_valid for this cycle,
                // so frame_done lands on the cycle right after it.
                spike_d      = '0;
                frame_done_d = 1'b1;
                state_d      = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            ptr_q         <= '0;
            win_q         <= '0;
            cnt_q         <= '0;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            cnt_q         <= cnt_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_we) begin
            pix_buf_q[ptr_q] <= pix_data;
        end
    end

`ifdef LFSR_SPIKE_COUNT_EN
    localparam int POP_W = $clog2(NUM_PIXELS + 1);
    localparam int TOT_W = CNT_W + POP_W;

    logic [POP_W-1:0] pop;
    logic [TOT_W-1:0] total_q, total_d;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            pop = pop + POP_W'(spike_q[i]);
        end
        total_d = total_q;
        if ((state_q == ST_READY) && start) begin
            total_d = '0;
        end else if (spike_valid_q) begin
            total_d = total_q + TOT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign spike_total = total_q;
`endif

    assign pix_ready   = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign spike       = spike_q;
    assign spike_valid = spike_valid_q;
    assign frame_done  = frame_done_q;
    assign lfsr0       = lfsr_state[0];

endmodule

// File: tb/tb_lfsr_spike_encoder_mc.sv
// ---------------------------------------------------------------------------
// tb_lfsr_spike_encoder_mc
// Directed bench for lfsr_spike_encoder_mc (default parameters). Expected
// spike vectors come from an independent LFSR model and are queued when a
// frame is started; a negedge monitor pops and compares them whenever
// spike_valid is high. Define LFSR_SPIKE_COUNT_EN to also check spike_total.
// ---------------------------------------------------------------------------
module tb_lfsr_spike_encoder_mc;

    localparam int NP = 784;
    localparam int PW = 8;
    localparam int LW = 16;
    localparam int NL = 4;
    localparam int CW = 16;
    localparam int TW = CW + $clog2(NP + 1);

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_ready;
    logic          start;
    logic [CW-1:0] window_cycles;
    logic          busy;
    logic [NP-1:0] spike;
    logic          spike_valid;
    logic          frame_done;
    logic [LW-1:0] lfsr0;
`ifdef LFSR_SPIKE_COUNT_EN
    logic [TW-1:0] spike_total;
`endif

    always #5 clk = ~clk;

    lfsr_spike_encoder_mc dut (
        .clk           (clk),
        .reset         (reset),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .start         (start),
        .window_cycles (window_cycles),
        .busy          (busy),
        .spike         (spike),
        .spike_valid   (spike_valid),
        .frame_done    (frame_done),
        .lfsr0         (lfsr0)
`ifdef LFSR_SPIKE_COUNT_EN
        ,
        .spike_total   (spike_total)
`endif
    );

    // ---------------- bench state ----------------
    logic [PW-1:0] img [NP];
    logic [LW-1:0] m_lfsr [NL];
    logic [NP-1:0] exp_q [$];
    logic [TW-1:0] exp_total;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sv_count, fd_count, fd_cyc, p5_cnt, p6_cnt, start_cyc;
    int mon_bad;
    logic [NP-1:0] mon_exp;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [LW-1:0] model_seed(input int k);
        logic [31:0] p;
        logic [LW-1:0] s;
        p = 32'(k + 1) * 32'h9E3779B1;
        s = 16'hB60B ^ p[15:0];
        if (s == 16'hFFFF) s = '0;
        return s;
    endfunction

    function automatic logic [LW-1:0] model_step(input logic [LW-1:0] s);
        return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
    endfunction

    task automatic model_reseed();
        for (int k = 0; k < NL; k++) m_lfsr[k] = model_seed(k);
    endtask

    // Queue the expected vectors for a window and advance the model.
    task automatic prepare(input int win);
        logic [NP-1:0] v;
        logic [LW-1:0] s;
        exp_total = '0;
        for (int c = 0; c < win; c++) begin
            for (int i = 0; i < NP; i++) begin
                s = m_lfsr[i % NL];
                v[i] = (s[15:8] < img[i]);
            end
            exp_q.push_back(v);
            exp_total = exp_total + TW'($countones(v));
            for (int k = 0; k < NL; k++) m_lfsr[k] = model_step(m_lfsr[k]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_image(input bit gappy, input bit poke_start);
        for (int i = 0; i < NP; i++) begin
            pix_valid = 1'b1;
            pix_data  = img[i];
            if (i == NP - 1) check("ready_before_last_beat", 64'(pix_ready), 64'd1);
            @(posedge clk); #1;
            pix_valid = 1'b0;
            pix_data  = '0;
            if (gappy) begin
                if (poke_start && (i == 100 || i == 400)) begin
                    start = 1'b1;
                    window_cycles = 16'd5;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        check("ready_low_after_load", 64'(pix_ready), 64'd0);
        check("not_busy_in_ready", 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input int win);
        prepare(win);
        sv_count = 0;
        fd_count = 0;
        p5_cnt   = 0;
        p6_cnt   = 0;
        start = 1'b1;
        window_cycles = CW'(win);
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        for (int t = 0; t < win + 20 && fd_count == 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("spike_valid_cycles", 64'(sv_count), 64'(win));
        check("frame_done_pulses", 64'(fd_count), 64'd1);
        check("frame_done_cycle", 64'(fd_cyc), 64'(start_cyc + win + 1));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("lfsr0_track", 64'(lfsr0), 64'(m_lfsr[0]));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (spike_valid) begin
                sv_count++;
                p5_cnt += int'(spike[5]);
                p6_cnt += int'(spike[6]);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spike_unexpected cycle %0d actual spike_valid 1 required 0", cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (spike !== mon_exp) begin
                        errors++;
                        mon_bad = 0;
                        for (int i = NP - 1; i >= 0; i--) if (spike[i] !== mon_exp[i]) mon_bad = i;
                        $display("FAIL spike_vec cycle %0d bit %0d actual %b required %b",
                                 cyc, mon_bad, spike[mon_bad], mon_exp[mon_bad]);
                    end
                end
            end
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
                check("fd_spike_zero", 64'(|spike), 64'd0);
                check("fd_spike_valid_low", 64'(spike_valid), 64'd0);
`ifdef LFSR_SPIKE_COUNT_EN
                check("spike_total", 64'(spike_total), 64'(exp_total));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        pix_valid = 1'b0;
        pix_data = '0;
        start = 1'b0;
        window_cycles = '0;
        model_reseed();
        repeat (3) @(posedge clk);
        #1;
        check("rst_lfsr0_seed0", 64'(lfsr0), 64'h0000_CFBA);
        check("rst_pix_ready", 64'(pix_ready), 64'd1);
        check("rst_spike", 64'(|spike), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_spike_valid", 64'(spike_valid), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Gappy load with stray start pulses, then an empty window.
        for (int i = 0; i < NP; i++) img[i] = '0;
        load_image(1'b1, 1'b1);
        run_frame(0);
        check("lfsr0_untouched_win0", 64'(lfsr0), 64'h0000_CFBA);

        // All-zero image, window 100.
        load_image(1'b0, 1'b0);
        run_frame(100);

        // Rate and mapping.
        img[5] = 8'd255;
        img[6] = 8'd128;
        load_image(1'b0, 1'b0);
        run_frame(4096);
        check("rate_p5_ge_4060", 64'(p5_cnt >= 4060), 64'd1);
        check("rate_p6_near_half", 64'(p6_cnt >= 1898 && p6_cnt <= 2198), 64'd1);

        // Abort mid-window with an asynchronous reset.
        for (int i = 0; i < NP; i++) img[i] = PW'(i * 37);
        load_image(1'b0, 1'b0);
        prepare(200);
        sv_count = 0;
        fd_count = 0;
        start = 1'b1;
        window_cycles = 16'd200;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 300 && sv_count < 50; t++) @(negedge clk);
        check("abort_reached_run", 64'(busy), 64'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("abort_spike_clear", 64'(|spike), 64'd0);
        check("abort_sv_clear", 64'(spike_valid), 64'd0);
        check("abort_busy_clear", 64'(busy), 64'd0);
        check("abort_pix_ready", 64'(pix_ready), 64'd1);
        check("abort_lfsr0_seed", 64'(lfsr0), 64'h0000_CFBA);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_frame_done", 64'(fd_count), 64'd0);
        check("abort_state_load", 64'(pix_ready), 64'd1);
        model_reseed();
        load_image(1'b0, 1'b0);
        run_frame(30);

`ifdef LFSR_SPIKE_COUNT_EN
        for (int i = 0; i < NP; i++) img[i] = 8'd255;
        load_image(1'b0, 1'b0);
        run_frame(10);
        check("total_bound", 64'(exp_total <= TW'(7840)), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
